// File: rtl/ddr_link_pkg.sv
// Shared types and width helpers for the downstream DDR link receiver.
package ddr_link_pkg;

  localparam int DEF_CHANNEL_WIDTH = 8;
  localparam int DEF_NUM_CHANNELS  = 2;

  function automatic int beat_width(input int cw, input int nc);
    return cw * nc;
  endfunction

  localparam int BEAT_W = beat_width(DEF_CHANNEL_WIDTH, DEF_NUM_CHANNELS);
  localparam int WORD_W = 2 * BEAT_W;

  typedef enum logic {
    RX_LOW  = 1'b0,
    RX_HIGH = 1'b1
  } rx_phase_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PROTO = 2'd1,
    ERR_OVF   = 2'd2
  } err_cause_e;

endpackage

// File: rtl/ddr_link_downstream_rx_if.sv
// Link-side beats plus core-side valid/ready word stream of the downstream receiver.
// err_count_o exists only when DDR_LINK_RX_ERR_COUNT_EN is defined.
interface ddr_link_downstream_rx_if
  import ddr_link_pkg::*;
#(
  parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int LG_FIFO_DEPTH = 3
);
  localparam int BW = beat_width(CHANNEL_WIDTH, NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0]  io_valid_i;
  logic [BW-1:0]            io_data_i;
  logic                     core_valid_o;
  logic [2*BW-1:0]          core_data_o;
  logic                     core_ready_i;
  logic                     token_clk_o;
  logic                     err_o;
  logic [LG_FIFO_DEPTH:0]   fifo_count_o;
`ifdef DDR_LINK_RX_ERR_COUNT_EN
  logic [7:0]               err_count_o;
`endif

  modport master (
    output io_valid_i, io_data_i, core_ready_i,
    input  core_valid_o, core_data_o, token_clk_o, err_o, fifo_count_o
`ifdef DDR_LINK_RX_ERR_COUNT_EN
    , input err_count_o
`endif
  );

  modport slave (
    input  io_valid_i, io_data_i, core_ready_i,
    output core_valid_o, core_data_o, token_clk_o, err_o, fifo_count_o
`ifdef DDR_LINK_RX_ERR_COUNT_EN
    , output err_count_o
`endif
  );

endinterface

// File: rtl/ddr_link_rx_fifo.sv
// Register-array FIFO with wrapping pointers; head is the entry at the read pointer.
module ddr_link_rx_fifo #(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    head_o,
  output logic [LG_DEPTH:0]   count_o,
  output logic                full_o,
  output logic                empty_o
);
  localparam int DEPTH = 1 << LG_DEPTH;

  logic [WIDTH-1:0]    mem_reg [DEPTH];
  logic [LG_DEPTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LG_DEPTH:0]   count_reg;
  logic                do_push, do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (LG_DEPTH+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);

  // Entries are cleared so the head reads zero after reset until the first write.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (do_push && wr_ptr_reg == LG_DEPTH'(gi)) begin
        mem_reg[gi] <= data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + LG_DEPTH'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + LG_DEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (LG_DEPTH+1)'(1);
        2'b01:   count_reg <= count_reg - (LG_DEPTH+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_o  = mem_reg[rd_ptr_reg];
  assign count_o = count_reg;

endmodule

// File: rtl/ddr_link_downstream_rx.sv
// DDR link receiver: pairs beats into words, buffers them, returns credits as a toggle line.
// Optional saturating error counter enabled by DDR_LINK_RX_ERR_COUNT_EN.
module ddr_link_downstream_rx
  import ddr_link_pkg::*;
#(
  parameter int CHANNEL_WIDTH    = DEF_CHANNEL_WIDTH,
  parameter int NUM_CHANNELS     = DEF_NUM_CHANNELS,
  parameter int LG_FIFO_DEPTH    = 3,
  parameter int TOKEN_DECIMATION = 4
) (
  input logic clk,
  input logic rst,
  ddr_link_downstream_rx_if.slave bus
);
  localparam int BW = beat_width(CHANNEL_WIDTH, NUM_CHANNELS);
  localparam int WW = 2 * BW;

  rx_phase_e              state_reg, state_next;
  logic [BW-1:0]          low_reg;
  logic                   all_valid, partial_valid;
  logic                   low_load, push, proto_err, overflow, pop;
  err_cause_e             err_cause;
  logic                   err_reg, token_reg;
  logic [WW-1:0]          head;
  logic [LG_FIFO_DEPTH:0] count;
  logic                   full, empty;

  assign all_valid     = &bus.io_valid_i;
  assign partial_valid = (|bus.io_valid_i) & ~all_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RX_LOW;
      low_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (low_load) low_reg <= bus.io_data_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    low_load   = 1'b0;
    push       = 1'b0;
    proto_err  = 1'b0;
    if (partial_valid) begin
      proto_err  = 1'b1;
      state_next = RX_LOW;
    end else begin
      case (state_reg)
        RX_LOW: begin
          if (all_valid) begin
            low_load   = 1'b1;
            state_next = RX_HIGH;
          end
        end
        RX_HIGH: begin
          // A missing second beat abandons the half-built word.
          if (all_valid) push = 1'b1;
          else           proto_err = 1'b1;
          state_next = RX_LOW;
        end
        default: state_next = RX_LOW;
      endcase
    end
  end

  ddr_link_rx_fifo #(
    .WIDTH    (WW),
    .LG_DEPTH (LG_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({bus.io_data_i, low_reg}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pop      = ~empty & bus.core_ready_i;
  assign overflow = push & full & ~pop;

  always_comb begin
    err_cause = ERR_NONE;
    if (proto_err)     err_cause = ERR_PROTO;
    else if (overflow) err_cause = ERR_OVF;
  end

  always_ff @(posedge clk) begin
    if (rst)                        err_reg <= 1'b0;
    else if (err_cause != ERR_NONE) err_reg <= 1'b1;
  end

  // One credit toggle per TOKEN_DECIMATION pops.
  if (TOKEN_DECIMATION == 1) begin : g_tok_every
    always_ff @(posedge clk) begin
      if (rst)      token_reg <= 1'b0;
      else if (pop) token_reg <= ~token_reg;
    end
  end else begin : g_tok_div
    localparam int TL = $clog2(TOKEN_DECIMATION);
    logic [TL-1:0] tok_cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        tok_cnt_reg <= '0;
        token_reg   <= 1'b0;
      end else if (pop) begin
        tok_cnt_reg <= tok_cnt_reg + TL'(1);
        if (tok_cnt_reg == '1) token_reg <= ~token_reg;
      end
    end
  end

`ifdef DDR_LINK_RX_ERR_COUNT_EN
  logic [7:0] err_cnt_reg;
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_reg <= '0;
    else if (err_cause != ERR_NONE && err_cnt_reg != 8'hFF)
      err_cnt_reg <= err_cnt_reg + 8'd1;
  end
  assign bus.err_count_o = err_cnt_reg;
`endif

  assign bus.core_valid_o = ~empty;
  assign bus.core_data_o  = head;
  assign bus.fifo_count_o = count;
  assign bus.err_o        = err_reg;
  assign bus.token_clk_o  = token_reg;

endmodule

// File: tb/tb_ddr_link_downstream_rx.sv
// Directed bench for ddr_link_downstream_rx: inputs driven and outputs checked on the falling edge.
module tb_ddr_link_downstream_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ddr_link_downstream_rx_if bus ();

  ddr_link_downstream_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.io_valid_i   = 2'b00;
    bus.io_data_i    = 16'h0;
    bus.core_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bus.io_valid_i = 2'b11;
    bus.io_data_i  = w[15:0];
    @(negedge clk);
    bus.io_data_i  = w[31:16];
    @(negedge clk);
    bus.io_valid_i = 2'b00;
    bus.io_data_i  = 16'h0;
  endtask

  function automatic logic [31:0] word_k(input int k);
    return 32'hA000_5000 + (32'(k) << 16) + 32'(k);
  endfunction

  initial begin
    // Reset values
    do_reset();
    check("rst_valid", bus.core_valid_o, 0);
    check("rst_data",  bus.core_data_o,  0);
    check("rst_token", bus.token_clk_o,  0);
    check("rst_err",   bus.err_o,        0);
    check("rst_count", bus.fifo_count_o, 0);

    // 1: single word, then pop
    send_word(32'h7856_3412);
    check("t1_valid", bus.core_valid_o, 1);
    check("t1_data",  bus.core_data_o,  32'h7856_3412);
    check("t1_count", bus.fifo_count_o, 1);
    bus.core_ready_i = 1'b1;
    @(negedge clk);
    bus.core_ready_i = 1'b0;
    check("t1_count_after_pop", bus.fifo_count_o, 0);
    check("t1_valid_after_pop", bus.core_valid_o, 0);

    // 2: fill to 8, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) send_word(word_k(i));
    check("t2_count_full", bus.fifo_count_o, 8);
    check("t2_err_clean",  bus.err_o,        0);
    check("t2_head",       bus.core_data_o,  word_k(0));
    send_word(32'h9999_9999);
    check("t2_err_ovf",    bus.err_o,        1);
    check("t2_count_ovf",  bus.fifo_count_o, 8);
    check("t2_head_ovf",   bus.core_data_o,  word_k(0));
`ifdef DDR_LINK_RX_ERR_COUNT_EN
    check("t2_err_count",  bus.err_count_o,  1);
`endif

    // 3: drain eight words, token toggles after pops 4 and 8
    bus.core_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_head", bus.core_data_o, word_k(i));
      @(negedge clk);
      check("t3_token", bus.token_clk_o, ((i + 1) / 4) % 2);
      check("t3_count", bus.fifo_count_o, 7 - i);
    end
    bus.core_ready_i = 1'b0;
    check("t3_valid_empty", bus.core_valid_o, 0);

    // 4: missing second beat, then a good pair
    do_reset();
    bus.io_valid_i = 2'b11;
    bus.io_data_i  = 16'h1111;
    @(negedge clk);
    bus.io_valid_i = 2'b00;
    @(negedge clk);
    check("t4_err_proto",   bus.err_o,        1);
    check("t4_count_proto", bus.fifo_count_o, 0);
    send_word(32'hBBBB_AAAA);
    check("t4_count", bus.fifo_count_o, 1);
    check("t4_data",  bus.core_data_o,  32'hBBBB_AAAA);

    // 4b: partial valid bits
    do_reset();
    bus.io_valid_i = 2'b01;
    bus.io_data_i  = 16'h2222;
    @(negedge clk);
    bus.io_valid_i = 2'b00;
    check("t4b_err_partial", bus.err_o,        1);
    check("t4b_count",       bus.fifo_count_o, 0);

    // 5: full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 8; i++) send_word(word_k(i));
    bus.io_valid_i = 2'b11;
    bus.io_data_i  = 16'hBEEF;
    @(negedge clk);
    bus.io_data_i    = 16'hDEAD;
    bus.core_ready_i = 1'b1;
    @(negedge clk);
    bus.io_valid_i   = 2'b00;
    bus.core_ready_i = 1'b0;
    check("t5_count", bus.fifo_count_o, 8);
    check("t5_err",   bus.err_o,        0);
    check("t5_head",  bus.core_data_o,  word_k(1));

    // 6: four pops set the token, then reset while in the high phase
    do_reset();
    bus.core_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) send_word(word_k(i + 20));
    @(negedge clk);
    bus.core_ready_i = 1'b0;
    check("t6_token_set", bus.token_clk_o,  1);
    check("t6_drained",   bus.fifo_count_o, 0);
    for (int i = 0; i < 3; i++) send_word(word_k(i + 30));
    check("t6_count3", bus.fifo_count_o, 3);
    bus.io_valid_i = 2'b11;
    bus.io_data_i  = 16'h7777;
    @(negedge clk);
    rst = 1'b1;
    bus.io_data_i = 16'h8888;
    @(negedge clk);
    check("t6_rst_valid", bus.core_valid_o, 0);
    check("t6_rst_data",  bus.core_data_o,  0);
    check("t6_rst_token", bus.token_clk_o,  0);
    check("t6_rst_err",   bus.err_o,        0);
    check("t6_rst_count", bus.fifo_count_o, 0);
    rst = 1'b0;
    bus.io_valid_i = 2'b00;
    bus.io_data_i  = 16'h0;
    @(negedge clk);
    send_word(32'h1234_CDEF);
    check("t6_post_count", bus.fifo_count_o, 1);
    check("t6_post_data",  bus.core_data_o,  32'h1234_CDEF);
    check("t6_post_err",   bus.err_o,        0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
